fetch_decode_unit: RTL and testbench

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

---
 rtl/fetch_decode_unit_pkg.sv | 26 ++
 rtl/fetch_decode_unit_pc_counter.sv | 24 ++
 rtl/fetch_decode_unit.sv | 94 +++++++++
 tb/tb_fetch_decode_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_unit_pkg.sv
// rtl/fetch_decode_unit_pkg.sv - opcode constants, instruction field positions and FSM encoding
// Shared between the fetch/decode unit and the control unit.
package fetch_decode_unit_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 6;
  localparam int RD_MSB     = 5;
  localparam int RD_LSB     = 4;
  localparam int RS_MSB     = 3;
  localparam int RS_LSB     = 2;
  localparam int RT_MSB     = 1;
  localparam int RT_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DECODE = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/fetch_decode_unit_pc_counter.sv
// rtl/fetch_decode_unit_pc_counter.sv - next-fetch address register with wrapping incrementer
module pc_counter #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] r_pc_next;

  // Wraps modulo 2^PC_W silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_next <= '0;
    end else if (inc) begin
      r_pc_next <= r_pc_next + PC_W'(1);
    end
  end

  assign pc_next = r_pc_next;

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - fetch/decode stage: FETCH, WAIT, DECODE sequencing with downstream stall
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [1:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic [1:0]         rt_addr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc
);

  fsm_state_e         r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_imem_rd;
  logic               r_instr_valid;
  logic               w_inc;
  logic [PC_W-1:0]    w_pc_next;

  assign w_inc = (r_state == ST_DECODE) && !stall;

  pc_counter #(.PC_W(PC_W)) u_pc_counter (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_inc),
    .pc_next (w_pc_next)
  );

  // imem_rd and instr_valid are set on the edge entering their state so they are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_pc          <= '0;
      r_imem_rd     <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state   <= ST_FETCH;
            r_imem_rd <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_state   <= ST_WAIT;
          r_imem_rd <= 1'b0;
          r_pc      <= w_pc_next;
        end
        ST_WAIT: begin
          r_instr       <= imem_data;
          r_state       <= ST_DECODE;
          r_instr_valid <= 1'b1;
        end
        ST_DECODE: begin
          if (!stall) begin
            r_instr_valid <= 1'b0;
            if (run) begin
              r_state   <= ST_FETCH;
              r_imem_rd <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = w_pc_next;
  assign imem_rd     = r_imem_rd;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;

  assign opcode  = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign rd      = r_instr[RD_MSB:RD_LSB];
  assign rs      = r_instr[RS_MSB:RS_LSB];
  assign rt_addr = r_instr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] imem_addr;
  logic       imem_rd;
  logic [7:0] imem_data = 8'h00;
  logic [1:0] opcode, rd, rs, rt_addr;
  logic       instr_valid;
  logic [3:0] pc;

  logic [7:0] mem [16];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         m_pc = 0;

  fetch_decode_unit #(.PC_W(4), .INSTR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .rt_addr     (rt_addr),
    .instr_valid (instr_valid),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous instruction memory: data one cycle after the read strobe.
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Run one instruction at address m_pc through FETCH/WAIT/DECODE, optionally holding
  // stall for stall_n cycles in DECODE, or dropping run during WAIT.
  task automatic run_instr(input int stall_n, input bit drop_run, output int vcyc);
    int   fcyc;
    int   fetches;
    bit   got;
    logic [7:0] e;
    fcyc = -1; fetches = 0; got = 0; vcyc = -1;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (imem_rd) begin
        fetches++;
        if (fcyc < 0) begin
          fcyc = cyc;
          check("fetch_addr", int'(imem_addr), m_pc);
        end
      end
      if (drop_run && fcyc >= 0 && cyc == fcyc + 1) run = 1'b0;
      if (instr_valid) got = 1;
    end
    check("valid_seen", int'(got), 1);
    if (!got) return;
    vcyc = cyc;
    e = mem[m_pc];
    check("fetch_to_valid", cyc - fcyc, 2);
    check("fetch_count", fetches, 1);
    check("opcode", int'(opcode), int'(e) / 64);
    check("rd", int'(rd), (int'(e) / 16) % 4);
    check("rs", int'(rs), (int'(e) / 4) % 4);
    check("rt_addr", int'(rt_addr), int'(e) % 4);
    check("pc", int'(pc), m_pc);
    if (stall_n > 0) begin
      stall = 1'b1;
      for (int s = 0; s < stall_n; s++) begin
        @(negedge clk);
        check("stall_valid", int'(instr_valid), 1);
        check("stall_fields", int'({opcode, rd, rs, rt_addr}), int'(e));
        check("stall_pc", int'(pc), m_pc);
        check("stall_no_rd", int'(imem_rd), 0);
      end
      stall = 1'b0;
    end
    m_pc = (m_pc + 1) % 16;
  endtask

  initial begin
    int v, prev_v, k;
    bit seen;

    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[0] = 8'b00_01_10_11;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_imem_rd", int'(imem_rd), 0);
    check("rst_valid", int'(instr_valid), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_addr", int'(imem_addr), 0);
    check("rst_fields", int'({opcode, rd, rs, rt_addr}), 0);

    // First instruction, then a 4-cycle stall, then the next fetch at address 1
    reset = 1'b0;
    run   = 1'b1;
    m_pc  = 0;
    run_instr(4, 0, v);
    check("first_valid_cycle", v, 3 + (v - 3));
    run_instr(0, 0, v);

    // 17 back-to-back instructions from a fresh reset: pc 0..15 then 0, spaced 3 cycles
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    prev_v = -1;
    for (int i = 0; i < 17; i++) begin
      check("seq_pc_expect", m_pc, i % 16);
      run_instr(0, 0, v);
      if (prev_v >= 0) check("valid_spacing", v - prev_v, 3);
      prev_v = v;
    end

    // Random stall lengths
    for (int i = 0; i < 12; i++) begin
      mem[m_pc] = 8'($urandom);
      run_instr(int'($urandom_range(0, 3)), 0, v);
    end

    // run dropped during WAIT: instruction completes, then the unit goes idle
    run_instr(0, 1, v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_no_rd", int'(imem_rd), 0);
      check("idle_no_valid", int'(instr_valid), 0);
    end

    // Reset during WAIT discards the in-flight instruction
    mem[1] = 8'h40; mem[2] = 8'h80; mem[3] = 8'hC0;
    run = 1'b1;
    seen = 0;
    k = 0;
    while (!seen && k < 6) begin
      @(negedge clk);
      if (imem_rd) seen = 1;
      k++;
    end
    check("pre_rst_fetch", int'(seen), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("wait_rst_imem_rd", int'(imem_rd), 0);
    check("wait_rst_valid", int'(instr_valid), 0);
    check("wait_rst_pc", int'(pc), 0);
    check("wait_rst_addr", int'(imem_addr), 0);
    check("wait_rst_fields", int'({opcode, rd, rs, rt_addr}), 0);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0;
    run_instr(0, 0, v);

    // Opcodes 01, 10, 11 pass through unchanged
    for (int i = 1; i <= 3; i++) begin
      run_instr(0, 0, v);
      check("opcode_hex", int'(opcode), i);
    end

    run = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
